// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {HZ_RUN, HZ_MEM_WAIT, HZ_FLUSH} hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Wide enough for FLUSH_CYCLES-1 with FLUSH_CYCLES up to 4.
  localparam int unsigned FlushCntW = 3;

  function automatic logic load_use_hit(input logic       memread,
                                        input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt,
                                        input logic       uses_rt);
    return memread && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_counters.sv
// Stall and flush cycle counters for the hazard unit; built only with HAZARD_PERF_CNT_EN.
module hazard_perf_counters #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_inc_i,
  input  logic                 flush_inc_i,
  output logic [CNT_WIDTH-1:0] stall_cycles_o,
  output logic [CNT_WIDTH-1:0] flush_cycles_o
);

  logic [CNT_WIDTH-1:0] stall_q, stall_d;
  logic [CNT_WIDTH-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_inc_i ? stall_q + 1'b1 : stall_q;
    flush_d = flush_inc_i ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_cycles_o = flush_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard controller: load-use bubble, branch flush, data-memory freeze.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 IDEX_memread_ctrl,
  input  logic [4:0]           IDEX_reg_rt,
  input  logic [4:0]           IFID_reg_rs,
  input  logic [4:0]           IFID_reg_rt,
  input  logic                 IFID_uses_rt,
  input  logic                 branch_taken,
  input  logic                 EXMEM_memaccess,
  input  logic                 dmem_ready,
  output logic                 pc_write_en,
  output logic                 IFID_write_en,
  output logic                 IDEX_bubble,
  output logic                 IFID_flush,
  output logic                 pipe_freeze,
  output logic [CNT_WIDTH-1:0] stall_cycles,
  output logic [CNT_WIDTH-1:0] flush_cycles
);

  hz_state_t              state_q, state_d;
  logic [FlushCntW-1:0]   flush_cnt_q, flush_cnt_d;
  logic                   lu_hit, mem_wait;

  assign lu_hit   = load_use_hit(IDEX_memread_ctrl, IDEX_reg_rt, IFID_reg_rs, IFID_reg_rt,
                                 IFID_uses_rt);
  assign mem_wait = EXMEM_memaccess && !dmem_ready;

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    pc_write_en   = 1'b1;
    IFID_write_en = 1'b1;
    IDEX_bubble   = 1'b0;
    IFID_flush    = 1'b0;
    pipe_freeze   = 1'b0;
    if (!rst_n) begin
      // Outputs follow reset combinationally so they change the instant rst_n drops.
      pc_write_en   = 1'b0;
      IFID_write_en = 1'b0;
      IDEX_bubble   = 1'b1;
      IFID_flush    = 1'b1;
    end else begin
      case (state_q)
        HZ_RUN: begin
          if (mem_wait) begin
            pc_write_en   = 1'b0;
            IFID_write_en = 1'b0;
            pipe_freeze   = 1'b1;
            state_d       = HZ_MEM_WAIT;
          end else if (branch_taken) begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              flush_cnt_d = FlushCntW'(FLUSH_CYCLES - 1);
              state_d     = HZ_FLUSH;
            end
          end else if (lu_hit) begin
            pc_write_en   = 1'b0;
            IFID_write_en = 1'b0;
            IDEX_bubble   = 1'b1;
          end
        end
        HZ_MEM_WAIT: begin
          if (!dmem_ready) begin
            pc_write_en   = 1'b0;
            IFID_write_en = 1'b0;
            pipe_freeze   = 1'b1;
          end else begin
            // A flush interrupted by the wait picks up where it left off.
            state_d = (flush_cnt_q != '0) ? HZ_FLUSH : HZ_RUN;
          end
        end
        HZ_FLUSH: begin
          if (mem_wait) begin
            pc_write_en   = 1'b0;
            IFID_write_en = 1'b0;
            pipe_freeze   = 1'b1;
            state_d       = HZ_MEM_WAIT;
          end else begin
            IFID_flush  = 1'b1;
            IDEX_bubble = 1'b1;
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == FlushCntW'(1)) state_d = HZ_RUN;
          end
        end
        default: begin
          state_d     = HZ_RUN;
          flush_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HZ_RUN;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_inc_i   (!pc_write_en),
    .flush_inc_i   (IFID_flush),
    .stall_cycles_o(stall_cycles),
    .flush_cycles_o(flush_cycles)
  );
`else
  assign stall_cycles = '0;
  assign flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench: two instances (FLUSH_CYCLES=3 and 1) against a cycle-level model.
module tb_hazard_stall_unit;

  localparam int unsigned CW = 32;
  localparam logic [4:0] RST = 5'b00110;  // {pc_we, ifid_we, bubble, flush, freeze}
  localparam logic [4:0] DEF = 5'b11000;
  localparam logic [4:0] STL = 5'b00100;
  localparam logic [4:0] FLS = 5'b11110;
  localparam logic [4:0] FRZ = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       memread = 1'b0, uses_rt = 1'b0, br = 1'b0, memacc = 1'b0, rdy = 1'b1;
  logic [4:0] idex_rt = '0, ifid_rs = '0, ifid_rt = '0;

  logic [1:0]    pc_we, ifid_we, bub, fl, frz;
  logic [CW-1:0] st_cyc [2];
  logic [CW-1:0] fl_cyc [2];

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(CW)) u0 (
    .clk(clk), .rst_n(rst_n), .IDEX_memread_ctrl(memread), .IDEX_reg_rt(idex_rt),
    .IFID_reg_rs(ifid_rs), .IFID_reg_rt(ifid_rt), .IFID_uses_rt(uses_rt),
    .branch_taken(br), .EXMEM_memaccess(memacc), .dmem_ready(rdy),
    .pc_write_en(pc_we[0]), .IFID_write_en(ifid_we[0]), .IDEX_bubble(bub[0]),
    .IFID_flush(fl[0]), .pipe_freeze(frz[0]),
    .stall_cycles(st_cyc[0]), .flush_cycles(fl_cyc[0])
  );

  hazard_stall_unit #(.FLUSH_CYCLES(1), .CNT_WIDTH(CW)) u1 (
    .clk(clk), .rst_n(rst_n), .IDEX_memread_ctrl(memread), .IDEX_reg_rt(idex_rt),
    .IFID_reg_rs(ifid_rs), .IFID_reg_rt(ifid_rt), .IFID_uses_rt(uses_rt),
    .branch_taken(br), .EXMEM_memaccess(memacc), .dmem_ready(rdy),
    .pc_write_en(pc_we[1]), .IFID_write_en(ifid_we[1]), .IDEX_bubble(bub[1]),
    .IFID_flush(fl[1]), .pipe_freeze(frz[1]),
    .stall_cycles(st_cyc[1]), .flush_cycles(fl_cyc[1])
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_vec(input int i);
    return {pc_we[i], ifid_we[i], bub[i], fl[i], frz[i]};
  endfunction

  // Reference model: "frozen" flag plus number of flush cycles still owed.
  int            m_frozen [2];
  int            m_left   [2];
  int            m_fc     [2];
  logic [CW-1:0] m_st     [2];
  logic [CW-1:0] m_fl     [2];
  logic [4:0]    e;
  logic          mw, lu;

  initial begin
    m_fc[0] = 3; m_fc[1] = 1;
    for (int i = 0; i < 2; i++) begin
      m_frozen[i] = 0; m_left[i] = 0; m_st[i] = '0; m_fl[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      mw = memacc && !rdy;
      lu = memread && idex_rt != 5'd0 &&
           (idex_rt == ifid_rs || (uses_rt && idex_rt == ifid_rt));
      for (int i = 0; i < 2; i++) begin
        e = DEF;
        if (!rst_n) begin
          e = RST;
          m_frozen[i] = 0;
          m_left[i] = 0;
        end else if (m_frozen[i] != 0) begin
          if (!rdy) e = FRZ;
          else m_frozen[i] = 0;
        end else if (mw) begin
          e = FRZ;
          m_frozen[i] = 1;
        end else if (m_left[i] > 0) begin
          e = FLS;
          m_left[i]--;
        end else if (br) begin
          e = FLS;
          m_left[i] = m_fc[i] - 1;
        end else if (lu) begin
          e = STL;
        end
        chk($sformatf("outs_u%0d", i), 64'(dut_vec(i)), 64'(e));
`ifdef HAZARD_PERF_CNT_EN
        chk($sformatf("stall_cnt_u%0d", i), 64'(st_cyc[i]), rst_n ? 64'(m_st[i]) : 64'd0);
        chk($sformatf("flush_cnt_u%0d", i), 64'(fl_cyc[i]), rst_n ? 64'(m_fl[i]) : 64'd0);
        if (!rst_n) begin
          m_st[i] = '0;
          m_fl[i] = '0;
        end else begin
          if (!e[4]) m_st[i] = m_st[i] + 1'b1;
          if (e[1])  m_fl[i] = m_fl[i] + 1'b1;
        end
`else
        chk($sformatf("stall_cnt_u%0d", i), 64'(st_cyc[i]), 64'd0);
        chk($sformatf("flush_cnt_u%0d", i), 64'(fl_cyc[i]), 64'd0);
`endif
      end
    end
  end

  task automatic set_in(input logic mr, input logic [4:0] xr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic ur, input logic b,
                        input logic ma, input logic rd);
    memread = mr; idex_rt = xr; ifid_rs = rs; ifid_rt = rt;
    uses_rt = ur; br = b; memacc = ma; rdy = rd;
  endtask

  task automatic drive(input logic mr, input logic [4:0] xr, input logic [4:0] rs,
                       input logic [4:0] rt, input logic ur, input logic b,
                       input logic ma, input logic rd);
    @(posedge clk);
    #1;
    set_in(mr, xr, rs, rt, ur, b, ma, rd);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic lit(input string nm, input logic [4:0] e0, input logic [4:0] e1);
    @(negedge clk);
    #2;
    chk({nm, "_u0"}, 64'(dut_vec(0)), 64'(e0));
    chk({nm, "_u1"}, 64'(dut_vec(1)), 64'(e1));
  endtask

  initial begin
    chk_en = 1'b1;
    lit("reset", RST, RST);
    @(posedge clk);
    #1 rst_n = 1'b1;
    lit("idle", DEF, DEF);

    // Memory wait for 4 cycles, branch during the wait is ignored.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("mw1", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); lit("mw2_br", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("mw3", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("mw4", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); lit("mw_rel", DEF, DEF);
`ifdef HAZARD_PERF_CNT_EN
    chk("stall_after_mw", 64'(st_cyc[0]), 64'd4);
    chk("flush_after_mw", 64'(fl_cyc[0]), 64'd0);
`endif
    idle(); lit("mw_after", DEF, DEF);

    // Load-use cases.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1); lit("lu_rs", STL, STL);
    idle(); lit("lu_after", DEF, DEF);
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1); lit("lu_r0", DEF, DEF);
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1); lit("lu_rt", STL, STL);
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1); lit("lu_rt_unused", DEF, DEF);

    // Branch flush: 3 cycles on u0, 1 on u1.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); lit("br1", FLS, FLS);
    idle(); lit("br2", FLS, DEF);
    idle(); lit("br3", FLS, DEF);
    idle(); lit("br_end", DEF, DEF);

    // Priority: branch over load-use, freeze over branch.
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); lit("br_lu", FLS, FLS);
    idle(); lit("br_lu2", FLS, DEF);
    idle(); lit("br_lu3", FLS, DEF);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); lit("mw_br", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); lit("mw_br_rel", DEF, DEF);

    // Flush interrupted by a memory wait resumes afterwards.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1); lit("fi_br", FLS, FLS);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("fi_mw", FRZ, FRZ);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1); lit("fi_rel", DEF, DEF);
    idle(); lit("fi_res1", FLS, DEF);
    idle(); lit("fi_res2", FLS, DEF);
    idle(); lit("fi_end", DEF, DEF);

    // Asynchronous reset in the middle of a memory wait.
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); lit("ar_mw", FRZ, FRZ);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_u0", 64'(dut_vec(0)), 64'(RST));
    chk("async_rst_u1", 64'(dut_vec(1)), 64'(RST));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    lit("ar_release", DEF, DEF);

    // Randomized phase, with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      rst_n = ($urandom_range(0, 99) >= 2);
      set_in($urandom_range(0, 9) < 3, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) < 15, $urandom_range(0, 9) < 3,
             $urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
